// File: rtl/mul_pkg.sv
// Shared types and constants for the 4x4 sequential shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_W     = 4;
  localparam int PROD_W    = 8;
  localparam int MUL_STEPS = 4;

endpackage

// File: rtl/seq_mul4_adder.sv
// 4-bit ripple add stage; the multiplier's only arithmetic resource.
module seq_mul4_adder (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + {4'b0000, cin};

endmodule

// File: rtl/seq_mul4.sv
// 4x4 unsigned shift-and-add multiplier: one partial-product add per cycle,
// valid/ready on both sides, 8-bit registered product after 4 compute steps.
module seq_mul4
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [3:0]        hi_q, hi_d;
  logic [3:0]        lo_q, lo_d;
  logic [3:0]        mcand_q, mcand_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              ov_q, ov_d;

  logic [3:0]        add_s;
  logic              add_c;
  logic [3:0]        step_s;
  logic              step_c;
  logic              last_step;

  seq_mul4_adder u_adder (
    .x    (hi_q),
    .y    (mcand_q),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_c)
  );

  // Skip the add when the current multiplier bit is zero.
  always_comb begin
    step_s = hi_q;
    step_c = 1'b0;
    if (lo_q[0]) begin
      step_s = add_s;
      step_c = add_c;
    end
  end

  assign last_step = (cnt_q == 2'(MUL_STEPS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)               state_d = BUSY;
      BUSY:    if (last_step)              state_d = DONE;
      DONE:    if (ov_q && out_ready)      state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
  end

  // Datapath: carry-out shifts into hi[3], sum LSB shifts into lo[3].
  always_comb begin
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = 4'd0;
          cnt_d   = 2'd0;
        end
      end
      BUSY: begin
        hi_d  = {step_c, step_s[3:1]};
        lo_d  = {step_s[0], lo_q[3:1]};
        cnt_d = cnt_q + 2'd1;
        if (last_step) begin
          prod_d = {hi_d, lo_d};
          ov_d   = 1'b1;
        end
      end
      DONE: begin
        if (ov_q && out_ready) ov_d = 1'b0;
      end
      default: ov_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      hi_q    <= 4'd0;
      lo_q    <= 4'd0;
      mcand_q <= 4'd0;
      prod_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      ov_q    <= ov_d;
    end
  end

  assign out_valid = ov_q;
  assign product   = prod_q;

endmodule
